// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: opcodes, command field widths, command/issue structs.
// Also holds the command validity rule used by the sequencer.
package alsu_pkg;

  localparam int OPC_W = 3;
  localparam int DAT_W = 3;
  localparam int REP_W = 3;
  localparam int ERR_W = 4;

  localparam logic [OPC_W-1:0] OP_OR     = 3'd0;
  localparam logic [OPC_W-1:0] OP_XOR    = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD    = 3'd2;
  localparam logic [OPC_W-1:0] OP_MUL    = 3'd3;
  localparam logic [OPC_W-1:0] OP_SHIFT  = 3'd4;
  localparam logic [OPC_W-1:0] OP_ROTATE = 3'd5;

  typedef struct packed {
    logic [OPC_W-1:0]        opcode;
    logic signed [DAT_W-1:0] a;
    logic signed [DAT_W-1:0] b;
    logic                    cin;
    logic                    serial_in;
    logic                    direction;
    logic                    red_op_a;
    logic                    red_op_b;
    logic                    bypass_a;
    logic                    bypass_b;
  } alsu_vec_t;

  typedef struct packed {
    alsu_vec_t        vec;
    logic [REP_W-1:0] rpt;
  } cmd_t;

  function automatic logic is_multi(input logic [OPC_W-1:0] op);
    return (op == OP_SHIFT) || (op == OP_ROTATE);
  endfunction

  // Priority only decides which reduction request the ALSU honours first;
  // either one on a non-OR/XOR opcode is illegal, so the rule is symmetric.
  function automatic logic cmd_invalid(input alsu_vec_t v, input logic prio_a);
    logic [1:0] w_red;
    w_red = prio_a ? {v.red_op_a, v.red_op_b} : {v.red_op_b, v.red_op_a};
    return !(v.bypass_a || v.bypass_b) &&
           ((v.opcode == 3'd6) || (v.opcode == 3'd7) || ((|w_red) && (v.opcode[2:1] != 2'b00)));
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Command queue: DEPTH-entry circular buffer with occupancy count, no fall-through.
// Push ignored when full or flushing; flush and reset empty it in one cycle.
module alsu_cmd_fifo
  import alsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  cmd_t                     push_dat,
  input  logic                     pop,
  output cmd_t                     pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_dat = r_mem[r_rd_ptr];
  assign w_push  = push && !full && !flush;
  assign w_pop   = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/alsu_cmd_seq.sv
// Queues ALSU commands and issues them as registered operand vectors, repeating shift/rotate.
// Optional drop of illegal commands with error count under macro ALSU_CMD_SEQ_CHECK_EN.
module alsu_cmd_seq
  import alsu_pkg::*;
#(
  parameter int    DEPTH          = 4,
  parameter string INPUT_PRIORITY = "A"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     flush,
  input  logic [OPC_W-1:0]         cmd_opcode,
  input  logic signed [DAT_W-1:0]  cmd_a,
  input  logic signed [DAT_W-1:0]  cmd_b,
  input  logic                     cmd_cin,
  input  logic                     cmd_serial_in,
  input  logic                     cmd_direction,
  input  logic                     cmd_red_op_a,
  input  logic                     cmd_red_op_b,
  input  logic                     cmd_bypass_a,
  input  logic                     cmd_bypass_b,
  input  logic [REP_W-1:0]         cmd_repeat,
  output logic [OPC_W-1:0]         opcode,
  output logic signed [DAT_W-1:0]  A,
  output logic signed [DAT_W-1:0]  B,
  output logic                     cin,
  output logic                     serial_in,
  output logic                     direction,
  output logic                     red_op_A,
  output logic                     red_op_B,
  output logic                     bypass_A,
  output logic                     bypass_B,
  output logic                     issue_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_drop,
  output logic [ERR_W-1:0]         err_count
);

`ifdef ALSU_CMD_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t           r_state, w_state_nxt;
  alsu_vec_t        r_vec;
  logic             r_issue_vld;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_err_drop;
  logic [ERR_W-1:0] r_err_cnt;
  cmd_t             w_push_dat, w_head;
  logic             w_full, w_empty, w_pop, w_drop;

  assign w_push_dat = '{vec: '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, cin: cmd_cin,
                               serial_in: cmd_serial_in, direction: cmd_direction,
                               red_op_a: cmd_red_op_a, red_op_b: cmd_red_op_b,
                               bypass_a: cmd_bypass_a, bypass_b: cmd_bypass_b},
                        rpt: cmd_repeat};

  alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (cmd_valid),
    .push_dat (w_push_dat),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .count    (fifo_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_rep_cnt == '0) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_pop       = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign w_drop = CHECK_EN && w_pop && cmd_invalid(w_head.vec, PRIO_A);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A dropped command still consumes one ISSUE cycle, shown as the idle vector.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vec       <= '0;
      r_issue_vld <= 1'b0;
      r_rep_cnt   <= '0;
      r_err_drop  <= 1'b0;
    end else if (w_pop) begin
      r_err_drop <= w_drop;
      if (w_drop) begin
        r_vec       <= '0;
        r_issue_vld <= 1'b0;
        r_rep_cnt   <= '0;
      end else begin
        r_vec       <= w_head.vec;
        r_issue_vld <= 1'b1;
        r_rep_cnt   <= is_multi(w_head.vec.opcode) ? w_head.rpt : '0;
      end
    end else if (r_rep_cnt != '0) begin
      r_rep_cnt  <= r_rep_cnt - REP_W'(1);
      r_err_drop <= 1'b0;
    end else begin
      r_vec       <= '0;
      r_issue_vld <= 1'b0;
      r_err_drop  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            r_err_cnt <= '0;
    else if (w_drop && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
  end

  assign cmd_ready   = !w_full;
  assign busy        = (r_state == S_ISSUE) || (fifo_count != '0);
  assign opcode      = r_vec.opcode;
  assign A           = r_vec.a;
  assign B           = r_vec.b;
  assign cin         = r_vec.cin;
  assign serial_in   = r_vec.serial_in;
  assign direction   = r_vec.direction;
  assign red_op_A    = r_vec.red_op_a;
  assign red_op_B    = r_vec.red_op_b;
  assign bypass_A    = r_vec.bypass_a;
  assign bypass_B    = r_vec.bypass_b;
  assign issue_valid = r_issue_vld;
  assign err_drop    = r_err_drop;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Directed bench for alsu_cmd_seq: reset, single issue, repeat chaining, full queue,
// validity check, flush and mid-repeat reset, against hand-computed expectations.
module tb_alsu_cmd_seq;
  import alsu_pkg::*;

`ifdef ALSU_CMD_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cmd_valid, cmd_ready, flush;
  logic [2:0]        cmd_opcode, cmd_repeat;
  logic signed [2:0] cmd_a, cmd_b;
  logic              cmd_cin, cmd_serial_in, cmd_direction;
  logic              cmd_red_op_a, cmd_red_op_b, cmd_bypass_a, cmd_bypass_b;
  logic [2:0]        opcode;
  logic signed [2:0] A, B;
  logic              cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic              issue_valid, busy, err_drop;
  logic [2:0]        fifo_count;
  logic [3:0]        err_count;

  int n_cmp = 0;
  int n_err = 0;

  alsu_cmd_seq #(.DEPTH(4), .INPUT_PRIORITY("A")) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .flush(flush),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .cmd_serial_in(cmd_serial_in), .cmd_direction(cmd_direction),
    .cmd_red_op_a(cmd_red_op_a), .cmd_red_op_b(cmd_red_op_b),
    .cmd_bypass_a(cmd_bypass_a), .cmd_bypass_b(cmd_bypass_b), .cmd_repeat(cmd_repeat),
    .opcode(opcode), .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .issue_valid(issue_valid), .busy(busy), .fifo_count(fifo_count),
    .err_drop(err_drop), .err_count(err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cmd_valid = 1'b0; flush = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_repeat = '0;
    cmd_serial_in = 1'b0; cmd_direction = 1'b0;
    {cmd_red_op_a, cmd_red_op_b, cmd_bypass_a, cmd_bypass_b} = 4'b0000;
  endtask

  // flg = {red_op_a, red_op_b, bypass_a, bypass_b}
  task automatic offer(input logic [2:0] op, input logic signed [2:0] a, input logic signed [2:0] b,
                       input logic ci, input logic [2:0] rpt, input logic [3:0] flg);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_cin = ci; cmd_repeat = rpt;
    cmd_serial_in = 1'b0; cmd_direction = 1'b0;
    {cmd_red_op_a, cmd_red_op_b, cmd_bypass_a, cmd_bypass_b} = flg;
  endtask

  task automatic test_reset();
    quiet(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_iv: got %b want 0", issue_valid); end
    n_cmp++; if ({opcode, A, B} !== 9'd0) begin n_err++; $display("FAIL rst_vec: got %h want 0", {opcode, A, B}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({err_drop, err_count} !== 5'd0) begin n_err++; $display("FAIL rst_err: got %b want 0", {err_drop, err_count}); end
  endtask

  task automatic test_add();
    offer(OP_ADD, 3'sd3, -3'sd2, 1'b1, 3'd0, 4'b0000);
    tick(); quiet();
    n_cmp++; if ({fifo_count, issue_valid} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL add_queued: got cnt=%0d iv=%b want cnt=1 iv=0", fifo_count, issue_valid); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL add_iv: got %b want 1", issue_valid); end
    n_cmp++; if (opcode !== 3'd2) begin n_err++; $display("FAIL add_op: got %0d want 2", opcode); end
    n_cmp++; if (A !== 3'sd3 || B !== -3'sd2) begin n_err++; $display("FAIL add_ab: got A=%0d B=%0d want 3 -2", A, B); end
    n_cmp++; if (cin !== 1'b1) begin n_err++; $display("FAIL add_cin: got %b want 1", cin); end
    tick();
    n_cmp++; if ({issue_valid, opcode, A, B, cin} !== 11'd0) begin n_err++; $display("FAIL add_idle: got %h want 0", {issue_valid, opcode, A, B, cin}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_op [6];
    logic       exp_iv [6];
    exp_op = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd0};
    exp_iv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    offer(OP_SHIFT, 3'sd1, 3'sd0, 1'b0, 3'd3, 4'b0000);
    tick();
    offer(OP_XOR, 3'sd2, 3'sd1, 1'b0, 3'd5, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      tick(); quiet();
      n_cmp++; if (issue_valid !== exp_iv[i]) begin n_err++; $display("FAIL b2b_iv[%0d]: got %b want %b", i, issue_valid, exp_iv[i]); end
      n_cmp++; if (opcode !== exp_op[i]) begin n_err++; $display("FAIL b2b_op[%0d]: got %0d want %0d", i, opcode, exp_op[i]); end
    end
  endtask

  task automatic test_full();
    logic signed [2:0] av [7];
    logic [2:0]        exp_cnt [7];
    logic signed [2:0] got [$];
    av      = '{3'sd0, 3'sd1, 3'sd2, 3'sd3, -3'sd1, -3'sd2, -3'sd2};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) offer(OP_ROTATE, av[i], 3'sd0, 1'b0, 3'd7, 4'b0000);
      else        offer(OP_OR, av[i], 3'sd0, 1'b0, 3'd0, 4'b0000);
      tick();
      n_cmp++; if (fifo_count !== exp_cnt[i]) begin n_err++; $display("FAIL full_cnt[%0d]: got %0d want %0d", i, fifo_count, exp_cnt[i]); end
      n_cmp++; if (cmd_ready !== (exp_cnt[i] != 3'd4)) begin n_err++; $display("FAIL full_ready[%0d]: got %b want %b", i, cmd_ready, exp_cnt[i] != 3'd4); end
    end
    quiet();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (issue_valid && opcode == OP_OR) got.push_back(A);
    end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL full_issued: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== av[k+1]) begin n_err++; $display("FAIL full_order[%0d]: got %0d want %0d", k, got[k], av[k+1]); end
    end
  endtask

  task automatic test_check();
    offer(3'd6, 3'sd1, 3'sd1, 1'b0, 3'd0, 4'b0000);
    tick();
    offer(OP_ADD, 3'sd1, 3'sd1, 1'b0, 3'd0, 4'b1000);
    tick();
    n_cmp++; if ({issue_valid, err_drop, err_count} !== {!CHK, CHK, 4'(CHK)}) begin n_err++; $display("FAIL chk_first: got iv=%b drop=%b cnt=%0d want %b %b %0d", issue_valid, err_drop, err_count, !CHK, CHK, CHK); end
    n_cmp++; if (opcode !== (CHK ? 3'd0 : 3'd6)) begin n_err++; $display("FAIL chk_first_op: got %0d want %0d", opcode, CHK ? 0 : 6); end
    offer(3'd7, 3'sd2, 3'sd1, 1'b0, 3'd0, 4'b0010);
    tick(); quiet();
    n_cmp++; if ({issue_valid, err_drop, err_count} !== {!CHK, CHK, (CHK ? 4'd2 : 4'd0)}) begin n_err++; $display("FAIL chk_second: got iv=%b drop=%b cnt=%0d", issue_valid, err_drop, err_count); end
    n_cmp++; if (red_op_A !== !CHK) begin n_err++; $display("FAIL chk_second_red: got %b want %b", red_op_A, !CHK); end
    tick();
    n_cmp++; if ({issue_valid, opcode, bypass_A} !== {1'b1, 3'd7, 1'b1}) begin n_err++; $display("FAIL chk_third: got iv=%b op=%0d bypA=%b want 1 7 1", issue_valid, opcode, bypass_A); end
    n_cmp++; if ({err_drop, err_count} !== {1'b0, (CHK ? 4'd2 : 4'd0)}) begin n_err++; $display("FAIL chk_third_err: got drop=%b cnt=%0d", err_drop, err_count); end
    tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL chk_idle: got %b want 0", issue_valid); end
  endtask

  task automatic test_flush();
    int late_issue;
    late_issue = 0;
    offer(OP_ROTATE, 3'sd1, 3'sd0, 1'b0, 3'd7, 4'b0000);
    tick();
    offer(OP_OR, 3'sd1, 3'sd1, 1'b0, 3'd0, 4'b0000);
    tick(); quiet();
    tick();
    n_cmp++; if ({issue_valid, opcode, fifo_count} !== {1'b1, 3'd5, 3'd1}) begin n_err++; $display("FAIL fl_before: got iv=%b op=%0d cnt=%0d want 1 5 1", issue_valid, opcode, fifo_count); end
    offer(OP_XOR, 3'sd3, 3'sd3, 1'b0, 3'd0, 4'b0000);
    flush = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b want 1", cmd_ready); end
    tick(); quiet();
    n_cmp++; if ({issue_valid, opcode, A, B} !== 10'd0) begin n_err++; $display("FAIL fl_idle: got %h want 0", {issue_valid, opcode, A, B}); end
    n_cmp++; if ({fifo_count, busy} !== 4'd0) begin n_err++; $display("FAIL fl_count: got cnt=%0d busy=%b want 0 0", fifo_count, busy); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (issue_valid) late_issue++;
    end
    n_cmp++; if (late_issue != 0) begin n_err++; $display("FAIL fl_no_issue: got %0d issue cycles want 0", late_issue); end
  endtask

  task automatic test_rst_mid();
    int late_issue;
    late_issue = 0;
    offer(OP_ROTATE, 3'sd2, 3'sd1, 1'b1, 3'd7, 4'b0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      offer(OP_ADD, 3'sd1, 3'sd1, 1'b0, 3'd0, 4'b0000);
      tick();
    end
    quiet();
    n_cmp++; if ({issue_valid, fifo_count} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL rm_before: got iv=%b cnt=%0d want 1 3", issue_valid, fifo_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({issue_valid, opcode, A, B, cin} !== 11'd0) begin n_err++; $display("FAIL rm_vec: got %h want 0", {issue_valid, opcode, A, B, cin}); end
    n_cmp++; if ({fifo_count, busy, err_drop, err_count} !== 9'd0) begin n_err++; $display("FAIL rm_status: got cnt=%0d busy=%b drop=%b ecnt=%0d want 0", fifo_count, busy, err_drop, err_count); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (issue_valid) late_issue++;
    end
    n_cmp++; if (late_issue != 0) begin n_err++; $display("FAIL rm_no_issue: got %0d issue cycles want 0", late_issue); end
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_check();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alsu_cmd_seq.md
ALSU_CMD_SEQ -- requirements
Module: alsu_cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter INPUT_PRIORITY, default "A", the downstream ALSU setting, used only by the validity check.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have ports: cmd_valid in 1, command offered; cmd_ready out 1, command accepted when both high; flush in 1, discard queue and current issue.
REQ-005 SHALL have command fields (in): cmd_opcode 3, cmd_a 3 signed, cmd_b 3 signed, cmd_cin 1, cmd_serial_in 1, cmd_direction 1, cmd_red_op_a 1, cmd_red_op_b 1, cmd_bypass_a 1, cmd_bypass_b 1, cmd_repeat 3 (extra issue cycles for shift/rotate).
REQ-006 SHALL have ALSU-facing outputs (registered): opcode 3, A 3, B 3, cin 1, serial_in 1, direction 1, red_op_A 1, red_op_B 1, bypass_A 1, bypass_B 1, issue_valid 1.
REQ-007 SHALL have status outputs: busy 1, fifo_count $clog2(DEPTH)+1, err_drop 1, err_count 4.

Function
REQ-008 SHALL accept a command on any clk edge with cmd_valid && cmd_ready; cmd_ready = !full (combinational on FIFO state only, not on pop).
REQ-009 SHALL not fall through: a command pushed at edge N is poppable at edge N+1 earliest; first ALSU-facing outputs valid after edge N+1.
REQ-010 SHALL use FSM IDLE/ISSUE; IDLE->ISSUE on pop when FIFO non-empty; ISSUE->ISSUE back-to-back pop when repeat exhausted and FIFO non-empty; ISSUE->IDLE when repeat exhausted and FIFO empty.
REQ-011 SHALL hold a popped opcode 4 or 5 command on outputs with issue_valid=1 for cmd_repeat+1 cycles (1..8); all other opcodes issue exactly 1 cycle, cmd_repeat ignored.
REQ-012 SHALL drive in IDLE all ALSU-facing outputs and issue_valid to 0 (all-zero vector = OR of zeros, ALSU output 0, no LED blink).
REQ-013 SHALL classify a command invalid when no bypass bit set and (opcode in {6,7} or (red_op_a|red_op_b) with opcode[2:1]!=0).
REQ-014 SHALL drop an invalid popped command (outputs forced to IDLE vector that cycle), pulse err_drop for 1 cycle, increment err_count saturating at 15.
REQ-015 SHALL on flush: empty FIFO, abort current repeat, FSM->IDLE, outputs IDLE vector after that edge; flush beats simultaneous push (push discarded, cmd_ready still reflects pre-flush full).
REQ-016 SHALL report fifo_count = stored entries (0..DEPTH); simultaneous push and pop leaves count unchanged; busy = (state==ISSUE) || fifo_count!=0.
REQ-017 SHALL never overflow or underflow: push ignored when full, pop never attempted when empty.

Reset
REQ-018 SHALL on rst: FIFO empty, fifo_count 0, FSM IDLE, all ALSU-facing outputs 0, issue_valid 0, busy 0, err_drop 0, err_count 0, cmd_ready 1 in next cycle.
REQ-019 SHALL give rst priority over flush, push and pop; rst mid-repeat abandons the command with no further issue.

Configuration
REQ-020 SHALL with macro ALSU_CMD_SEQ_CHECK_EN defined implement REQ-013/014; undefined: invalid commands issued unchanged like valid ones, err_drop and err_count tied 0.

Structure
REQ-021 SHALL take opcode constants (OR, XOR, ADD, MUL, SHIFT, ROTATE), command field widths and the err_count width from shared package alsu_pkg.
REQ-022 SHALL instantiate one sub-module alsu_cmd_fifo (storage, pointers, count, full/empty); FSM, repeat counter and check stay in alsu_cmd_seq.

Verification
REQ-023 SHALL cover: push ADD a=3 b=-2 cin=1 at edge 0 -> edge 1 outputs opcode=2 A=3 B=-2 cin=1, issue_valid=1 for 1 cycle, then IDLE vector.
REQ-024 SHALL cover: push SHIFT repeat=3 then XOR back-to-back -> issue_valid high 5 consecutive cycles (4 shift, 1 xor), no gap.
REQ-025 SHALL cover: 5 pushes with no pop progress while DEPTH=4 holds one in issue -> cmd_ready low exactly when fifo_count=4, no entry lost or duplicated.
REQ-026 SHALL cover (CHECK_EN): push opcode 6 then red_op_a with ADD, then bypass_a with opcode 7 -> two err_drop pulses, err_count=2, third issued unchanged.
REQ-027 SHALL cover: flush during ROTATE repeat=7 cycle 2 with simultaneous push -> outputs IDLE next cycle, fifo_count=0, pushed command never issued.
REQ-028 SHALL cover: rst asserted mid-repeat with 3 queued -> all outputs and counters 0 next cycle, no later issue.
